// File: rtl/blink_code_scheduler_pkg.sv
// Shared types and helpers for the blink-code scheduler: FSM state encoding,
// 32-bit unsigned alias and the round-robin pointer advance.
package blink_code_scheduler_pkg;

  typedef int unsigned u32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } blink_state_t;

  // Pointer for the next arbitration round: one past the last winner, wrapping.
  function automatic u32 next_rr(input u32 winner, input u32 num_req);
    return (winner + 1) % num_req;
  endfunction

  function automatic u32 max3(input u32 a, input u32 b, input u32 c);
    u32 m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/blink_code_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the lowest-index requester at or
// above i_ptr, wrapping around to index 0.
module rr_arbiter
  import blink_code_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_valid
);

  logic [PTR_W-1:0] idx;

  // Scan requesters in priority order starting at the pointer; first hit wins.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((u32'(i_ptr) + i) % NUM_REQ);
      if (!o_valid && i_req[idx]) begin
        o_grant[idx] = 1'b1;
        o_valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/blink_code_scheduler.sv
// Blink-code scheduler: arbitrates status requesters onto one LED and emits
// the winner's code as N on-pulses separated by off-periods, then a gap.
module blink_code_scheduler
  import blink_code_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned TICK_DIV  = 1_200_000,
  parameter int unsigned ON_TICKS  = 2,
  parameter int unsigned OFF_TICKS = 3,
  parameter int unsigned GAP_TICKS = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*CNT_W-1:0] i_count,
  input  logic                     i_abort,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_led
);

  localparam u32 PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam u32 MAX_TICKS = max3(ON_TICKS, OFF_TICKS, GAP_TICKS);
  localparam u32 TK_W      = $clog2(MAX_TICKS + 1);
  localparam u32 PS_W      = $clog2(TICK_DIV);

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [TK_W-1:0] ON_T    = TK_W'(ON_TICKS);
  localparam logic [TK_W-1:0] OFF_T   = TK_W'(OFF_TICKS);
  localparam logic [TK_W-1:0] GAP_T   = TK_W'(GAP_TICKS);

  blink_state_t       state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               busy_q;
  logic               done_q;
  logic               led_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   win_q;
  logic [CNT_W-1:0]   pulses_q;
  logic [PS_W-1:0]    presc_q;
  logic [TK_W-1:0]    ticks_q;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] arb_grant;
  logic               arb_valid;
  logic [PTR_W-1:0]   win_idx_d;
  logic [CNT_W-1:0]   win_cnt_d;
  logic [CNT_W-1:0]   pulses_d;
  logic               tick;
  logic               phase_end;

  // Only requesters with a non-zero pulse count are allowed into arbitration.
  always_comb begin
    elig = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      elig[k] = i_req[k] && (i_count[k*CNT_W +: CNT_W] != '0);
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_req   (elig),
    .i_ptr   (ptr_q),
    .o_grant (arb_grant),
    .o_valid (arb_valid)
  );

  // Winner index/count decode, tick detection and pulse bookkeeping.
  always_comb begin
    win_idx_d = '0;
    win_cnt_d = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (arb_grant[k]) begin
        win_idx_d = PTR_W'(k);
        win_cnt_d = i_count[k*CNT_W +: CNT_W];
      end
    end
    tick      = (presc_q == PS_LAST);
    phase_end = tick && (ticks_q == TK_W'(1));
    pulses_d  = pulses_q - CNT_W'(1);
  end

  // Sequencer FSM with registered outputs; abort takes priority over phase ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      led_q    <= 1'b0;
      ptr_q    <= '0;
      win_q    <= '0;
      pulses_q <= '0;
      presc_q  <= '0;
      ticks_q  <= '0;
    end else begin
      done_q  <= 1'b0;
      presc_q <= tick ? '0 : presc_q + PS_W'(1);
      if (tick) ticks_q <= ticks_q - TK_W'(1);

      if (state_q != IDLE && i_abort) begin
        state_q <= IDLE;
        grant_q <= '0;
        busy_q  <= 1'b0;
        led_q   <= 1'b0;
        presc_q <= '0;
        ptr_q   <= PTR_W'(next_rr(u32'(win_q), NUM_REQ));
      end else begin
        unique case (state_q)
          IDLE: begin
            presc_q <= '0;
            if (arb_valid) begin
              state_q  <= ON;
              grant_q  <= arb_grant;
              win_q    <= win_idx_d;
              pulses_q <= win_cnt_d;
              ticks_q  <= ON_T;
              busy_q   <= 1'b1;
              led_q    <= 1'b1;
            end
          end
          ON: begin
            if (phase_end) begin
              presc_q  <= '0;
              pulses_q <= pulses_d;
              led_q    <= 1'b0;
              if (pulses_d != '0) begin
                state_q <= OFF;
                ticks_q <= OFF_T;
              end else begin
                state_q <= GAP;
                ticks_q <= GAP_T;
              end
            end
          end
          OFF: begin
            if (phase_end) begin
              presc_q <= '0;
              state_q <= ON;
              ticks_q <= ON_T;
              led_q   <= 1'b1;
            end
          end
          GAP: begin
            if (phase_end) begin
              presc_q <= '0;
              state_q <= IDLE;
              grant_q <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              ptr_q   <= PTR_W'(next_rr(u32'(win_q), NUM_REQ));
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_grant = grant_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_led   = led_q;

endmodule

// File: tb/tb_blink_code_scheduler.sv
// Self-checking bench for blink_code_scheduler with a small tick divider,
// plus an exhaustive check of the rr_arbiter sub-module.
module tb_blink_code_scheduler;

  localparam int NR   = 4;
  localparam int CW   = 4;
  localparam int TD   = 4;
  localparam int ONT  = 2;
  localparam int OFFT = 1;
  localparam int GAPT = 3;
  localparam int LIM  = 200;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     i_req;
  logic [NR*CW-1:0]  i_count;
  logic              i_abort;
  logic [NR-1:0]     o_grant;
  logic              o_busy;
  logic              o_done;
  logic              o_led;

  logic [NR-1:0]     a_req;
  logic [1:0]        a_ptr;
  logic [NR-1:0]     a_grant;
  logic              a_valid;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  blink_code_scheduler #(
    .NUM_REQ   (NR),
    .CNT_W     (CW),
    .TICK_DIV  (TD),
    .ON_TICKS  (ONT),
    .OFF_TICKS (OFFT),
    .GAP_TICKS (GAPT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (i_req),
    .i_count (i_count),
    .i_abort (i_abort),
    .o_grant (o_grant),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_led   (o_led)
  );

  rr_arbiter #(
    .NUM_REQ (NR)
  ) u_arb (
    .i_req   (a_req),
    .i_ptr   (a_ptr),
    .o_grant (a_grant),
    .o_valid (a_valid)
  );

  function automatic int onehot_idx(input logic [NR-1:0] g);
    if ($countones(g) != 1) return -1;
    for (int i = 0; i < NR; i++) if (g[i]) return i;
    return -1;
  endfunction

  // Expected LED level c cycles after the grant edge for an n-pulse code.
  function automatic bit led_model(input int c, input int n);
    int t;
    t = c;
    for (int p = 0; p < n; p++) begin
      if (t < ONT*TD) return 1'b1;
      t -= ONT*TD;
      if (p < n-1) begin
        if (t < OFFT*TD) return 1'b0;
        t -= OFFT*TD;
      end
    end
    return 1'b0;
  endfunction

  function automatic int seq_len(input int n);
    return n*ONT*TD + (n-1)*OFFT*TD + GAPT*TD;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_count(input int k, input int v);
    i_count[k*CW +: CW] = CW'(v);
  endtask

  task automatic wait_grant(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (o_grant === '0 && cyc < LIM);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (o_done !== 1'b1 && cyc < LIM);
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    i_req   = '0;
    i_count = '0;
    i_abort = 1'b0;
    tick(2);
    rst_n   = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    i_req   = '1;
    i_count = '1;
    i_abort = 1'b0;
    tick(2);
    checks++;
    if (o_grant !== '0) begin failures++; $display("FAIL reset_grant got=%b want=0000", o_grant); end
    checks++;
    if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", o_busy); end
    checks++;
    if (o_led !== 1'b0) begin failures++; $display("FAIL reset_led got=%b want=0", o_led); end
    checks++;
    if (o_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", o_done); end
    i_req   = '0;
    i_count = '0;
    rst_n   = 1'b1;
    tick(1);
  endtask

  task automatic test_single();
    int exp_idx, got, bad, tot;
    tot = seq_len(3);
    set_count(1, 3);
    i_req = 4'b0010;
    exp_q.push_back(1);
    tick(1);
    exp_idx = exp_q.pop_front();
    got = onehot_idx(o_grant);
    checks++;
    if (got !== exp_idx) begin failures++; $display("FAIL single_grant got=%b want_idx=%0d", o_grant, exp_idx); end
    checks++;
    if (o_led !== 1'b1 || o_busy !== 1'b1) begin
      failures++; $display("FAIL single_latency led=%b busy=%b want led=1 busy=1", o_led, o_busy);
    end
    i_req = '0;
    bad = 0;
    for (int c = 0; c < tot; c++) begin
      if (c > 0) tick(1);
      if (o_led !== led_model(c, 3) || o_busy !== 1'b1 || o_done !== 1'b0 || o_grant !== 4'b0010) begin
        if (bad == 0) $display("FAIL single_profile cycle=%0d led=%b want=%b busy=%b done=%b grant=%b",
                               c, o_led, led_model(c, 3), o_busy, o_done, o_grant);
        bad++;
      end
    end
    checks++;
    if (bad != 0) failures++;
    tick(1);
    checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_grant !== '0 || o_led !== 1'b0) begin
      failures++; $display("FAIL single_end done=%b busy=%b grant=%b led=%b want 1 0 0000 0", o_done, o_busy, o_grant, o_led);
    end
    tick(1);
    checks++;
    if (o_done !== 1'b0) begin failures++; $display("FAIL single_done_pulse got=%b want=0", o_done); end
  endtask

  task automatic test_contention();
    int cyc, len, got, exp_idx;
    apply_reset();
    for (int k = 0; k < NR; k++) set_count(k, 1);
    i_req = 4'b1011;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(0);
    for (int s = 0; s < 4; s++) begin
      wait_grant(cyc);
      exp_idx = exp_q.pop_front();
      got = onehot_idx(o_grant);
      checks++;
      if (got !== exp_idx) begin failures++; $display("FAIL contention_order seq=%0d got=%b want_idx=%0d", s, o_grant, exp_idx); end
      checks++;
      if (cyc !== 1) begin failures++; $display("FAIL contention_idle_gap seq=%0d got=%0d want=1", s, cyc); end
      if (s == 3) i_req = '0;
      wait_done(len);
      checks++;
      if (len !== seq_len(1)) begin failures++; $display("FAIL contention_len seq=%0d got=%0d want=%0d", s, len, seq_len(1)); end
      checks++;
      if (o_busy !== 1'b0 || o_led !== 1'b0) begin
        failures++; $display("FAIL contention_idle seq=%0d busy=%b led=%b want 0 0", s, o_busy, o_led);
      end
    end
    tick(2);
  endtask

  task automatic test_count_zero_drop();
    int cyc, guard, pulses, got, exp_idx;
    bit seen, prev;
    apply_reset();
    set_count(2, 0);
    i_req = 4'b0100;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      if (o_busy !== 1'b0 || o_grant !== '0) seen = 1'b1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL zero_count_granted got=1 want=0"); end
    set_count(0, 3);
    i_req = 4'b0101;
    exp_q.push_back(0);
    wait_grant(cyc);
    exp_idx = exp_q.pop_front();
    got = onehot_idx(o_grant);
    checks++;
    if (got !== exp_idx) begin failures++; $display("FAIL drop_grant got=%b want_idx=%0d", o_grant, exp_idx); end
    i_req = 4'b0100;
    set_count(0, 5);
    pulses = o_led ? 1 : 0;
    prev   = o_led;
    guard  = 0;
    while (o_done !== 1'b1 && guard < LIM) begin
      tick(1);
      guard++;
      if (o_led && !prev) pulses++;
      prev = o_led;
    end
    checks++;
    if (pulses !== 3 || o_done !== 1'b1) begin
      failures++; $display("FAIL drop_pulses got=%0d done=%b want=3 done=1", pulses, o_done);
    end
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      if (o_busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL zero_count_after got=busy want=idle"); end
    i_req = '0;
  endtask

  task automatic test_abort();
    int cyc, len, got, exp_idx;
    bit seen;
    apply_reset();
    set_count(1, 3);
    i_req = 4'b0010;
    exp_q.push_back(1);
    wait_grant(cyc);
    exp_idx = exp_q.pop_front();
    got = onehot_idx(o_grant);
    checks++;
    if (got !== exp_idx) begin failures++; $display("FAIL abort_first_grant got=%b want_idx=%0d", o_grant, exp_idx); end
    i_req = '0;
    tick(9);
    i_abort = 1'b1;
    tick(1);
    i_abort = 1'b0;
    checks++;
    if (o_led !== 1'b0 || o_busy !== 1'b0 || o_grant !== '0 || o_done !== 1'b0) begin
      failures++; $display("FAIL abort_outputs led=%b busy=%b grant=%b done=%b want 0 0 0000 0", o_led, o_busy, o_grant, o_done);
    end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick(1);
      if (o_done !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL abort_no_done got=1 want=0"); end
    set_count(1, 1);
    set_count(2, 1);
    i_req   = 4'b0110;
    i_abort = 1'b1;
    exp_q.push_back(2);
    tick(1);
    i_abort = 1'b0;
    i_req   = '0;
    exp_idx = exp_q.pop_front();
    got = onehot_idx(o_grant);
    checks++;
    if (got !== exp_idx || o_busy !== 1'b1) begin
      failures++; $display("FAIL abort_skip_grant got=%b busy=%b want_idx=%0d busy=1", o_grant, o_busy, exp_idx);
    end
    wait_done(len);
    checks++;
    if (len !== seq_len(1)) begin failures++; $display("FAIL abort_next_len got=%0d want=%0d", len, seq_len(1)); end
    tick(1);
  endtask

  task automatic test_reset_mid();
    int got, exp_idx, len;
    set_count(1, 2);
    i_req = 4'b0010;
    exp_q.push_back(1);
    tick(1);
    exp_idx = exp_q.pop_front();
    got = onehot_idx(o_grant);
    checks++;
    if (got !== exp_idx) begin failures++; $display("FAIL rstmid_first_grant got=%b want_idx=%0d", o_grant, exp_idx); end
    i_req = '0;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    checks++;
    if (o_grant !== '0 || o_busy !== 1'b0 || o_led !== 1'b0 || o_done !== 1'b0) begin
      failures++; $display("FAIL rstmid_outputs grant=%b busy=%b led=%b done=%b want 0000 0 0 0", o_grant, o_busy, o_led, o_done);
    end
    rst_n = 1'b1;
    set_count(0, 1);
    set_count(3, 1);
    i_req = 4'b1001;
    exp_q.push_back(0);
    tick(1);
    i_req = '0;
    exp_idx = exp_q.pop_front();
    got = onehot_idx(o_grant);
    checks++;
    if (got !== exp_idx) begin failures++; $display("FAIL rstmid_ptr_grant got=%b want_idx=%0d", o_grant, exp_idx); end
    wait_done(len);
    tick(1);
  endtask

  task automatic test_arbiter();
    logic [NR-1:0] exp_g;
    logic          exp_v;
    int            idx;
    for (int r = 0; r < 16; r++) begin
      for (int p = 0; p < NR; p++) begin
        a_req = NR'(r);
        a_ptr = 2'(p);
        #1;
        exp_g = '0;
        exp_v = 1'b0;
        for (int i = 0; i < NR; i++) begin
          idx = (p + i) % NR;
          if (!exp_v && a_req[idx]) begin
            exp_g[idx] = 1'b1;
            exp_v      = 1'b1;
          end
        end
        checks++;
        if (a_grant !== exp_g || a_valid !== exp_v) begin
          failures++; $display("FAIL arb req=%b ptr=%0d got=%b/%b want=%b/%b", a_req, p, a_grant, a_valid, exp_g, exp_v);
        end
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    i_req   = '0;
    i_count = '0;
    i_abort = 1'b0;
    a_req   = '0;
    a_ptr   = '0;
    test_reset();
    test_single();
    test_contention();
    test_count_zero_drop();
    test_abort();
    test_reset_mid();
    test_arbiter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
